// File: rtl/blackjack_pkg.sv
// blackjack_pkg: shoe state encoding, full-deck count table and sizing constants
package blackjack_pkg;
  typedef enum logic [1:0] {IDLE, REFILL, EMPTY} shoe_state_e;
  localparam int DECK_SIZE = 52;
  localparam int NUM_SEATS = 4;
  // Listed from index 15 down: five unused values, sixteen ten-valued cards, nine ranks of four, unused 0
  localparam logic [15:0][4:0] FULL_DECK = {{5{5'd0}}, 5'd16, {9{5'd4}}, 5'd0};
  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction
endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: combinational 4-way round-robin pick, searching from i_ptr upward
module rr_arbiter4 (
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [3:0] o_gnt,
  output logic       o_any
);
  logic [7:0] w_dbl, w_back;
  logic [3:0] w_rot, w_first;
  always_comb begin
    w_dbl = {i_req, i_req} >> i_ptr;
    w_rot = w_dbl[3:0];
    w_first = w_rot & (~w_rot + 4'd1);
    w_back = {w_first, w_first} << i_ptr;
    o_gnt = w_back[7:4];
    o_any = |i_req;
  end
endmodule

// File: rtl/card_shoe_arbiter.sv
// card_shoe_arbiter: deals cards from a 52-card shoe to four seats round-robin,
// with a 16-cycle refill on shuffle
module card_shoe_arbiter
  import blackjack_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_SEATS-1:0] req,
  input  logic [3:0]           pick,
  input  logic                 shuffle,
  output logic [NUM_SEATS-1:0] gnt,
  output logic [3:0]           card,
  output logic [5:0]           remaining,
  output logic                 empty,
  output logic                 busy,
  output logic                 stall
);
  shoe_state_e r_state, w_next;
  logic [15:0][4:0] r_cnt;
  logic [5:0] r_rem;
  logic [1:0] r_ptr;
  logic [3:0] r_idx, r_gnt, r_card, w_win;
  logic r_stall, w_any, w_valid, w_grant, w_stall;

  rr_arbiter4 u_arb (.i_req(req), .i_ptr(r_ptr), .o_gnt(w_win), .o_any(w_any));

  always_comb begin
    w_next = r_state;
    w_valid = r_cnt[pick] != 5'd0;
    w_grant = 1'b0;
    w_stall = 1'b0;
    case (r_state)
      IDLE: begin
        if (shuffle) w_next = REFILL;
        else if (r_rem == 6'd0) w_next = EMPTY;
        else if (w_any) begin
          w_grant = w_valid;
          w_stall = !w_valid;
          if (w_valid && r_rem == 6'd1) w_next = EMPTY;
        end
      end
      REFILL: if (r_idx == 4'd15) w_next = IDLE;
      EMPTY: if (shuffle) w_next = REFILL;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= FULL_DECK;
      r_rem <= 6'(DECK_SIZE);
      r_ptr <= 2'd0;
      r_idx <= 4'd0;
      r_gnt <= 4'd0;
      r_card <= 4'd0;
      r_stall <= 1'b0;
    end else begin
      r_gnt <= w_grant ? w_win : 4'd0;
      r_card <= w_grant ? pick : 4'd0;
      r_stall <= w_stall;
      if (w_grant) begin
        r_cnt[pick] <= r_cnt[pick] - 5'd1;
        r_rem <= r_rem - 6'd1;
        r_ptr <= onehot_idx(w_win) + 2'd1;
      end
      if (r_state != REFILL && w_next == REFILL) r_rem <= 6'd0;
      // r_idx wraps back to 0 on the last refill cycle, ready for the next shuffle
      if (r_state == REFILL) begin
        r_cnt[r_idx] <= FULL_DECK[r_idx];
        r_idx <= r_idx + 4'd1;
        if (r_idx == 4'd15) r_rem <= 6'(DECK_SIZE);
      end
    end
  end

  assign gnt = r_gnt;
  assign card = r_card;
  assign stall = r_stall;
  assign remaining = r_rem;
  assign empty = r_rem == 6'd0;
  assign busy = r_state == REFILL;
endmodule

// File: tb/tb_card_shoe_arbiter.sv
// tb_card_shoe_arbiter: scoreboard bench for card_shoe_arbiter against a behavioural shoe model
module tb_card_shoe_arbiter;
  import blackjack_pkg::*;
  logic clock, reset_n, shuffle, empty, busy, stall;
  logic [3:0] req, pick, gnt, card;
  logic [5:0] remaining;
  int n_err, n_chk;

  typedef struct {
    logic [3:0] gnt;
    logic [3:0] card;
    logic stall;
    int rem;
    logic busy;
    logic empty;
  } exp_t;
  exp_t q[$];

  int m_cnt[16];
  int m_rem, m_ptr, m_st, m_ridx;

  card_shoe_arbiter dut (
    .clock(clock), .reset_n(reset_n), .req(req), .pick(pick), .shuffle(shuffle),
    .gnt(gnt), .card(card), .remaining(remaining), .empty(empty), .busy(busy), .stall(stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int full(input int i);
    return (i == 10) ? 16 : (i >= 1 && i <= 9) ? 4 : 0;
  endfunction

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_cnt[i] = full(i);
    m_rem = 52;
    m_ptr = 0;
    m_st = 0;
    m_ridx = 0;
    q.delete();
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] p, input logic s);
    exp_t e;
    int w;
    @(negedge clock);
    req = r;
    pick = p;
    shuffle = s;
    e.gnt = 4'd0;
    e.card = 4'd0;
    e.stall = 1'b0;
    case (m_st)
      0: begin
        if (s) begin m_st = 1; m_ridx = 0; m_rem = 0; end
        else if (m_rem == 0) m_st = 2;
        else if (r != 4'd0) begin
          if (m_cnt[p] > 0) begin
            w = m_ptr;
            while (!r[w]) w = (w + 1) % 4;
            e.gnt = 4'd1 << w;
            e.card = p;
            m_cnt[p]--;
            m_rem--;
            m_ptr = (w + 1) % 4;
            if (m_rem == 0) m_st = 2;
          end else e.stall = 1'b1;
        end
      end
      1: begin
        m_cnt[m_ridx] = full(m_ridx);
        if (m_ridx == 15) begin m_st = 0; m_rem = 52; end
        else m_ridx++;
      end
      default: if (s) begin m_st = 1; m_ridx = 0; m_rem = 0; end
    endcase
    e.rem = m_rem;
    e.busy = m_st == 1;
    e.empty = m_rem == 0;
    q.push_back(e);
    @(posedge clock);
    #1;
    e = q.pop_front();
    chk("gnt", int'(gnt), int'(e.gnt));
    chk("card", int'(card), int'(e.card));
    chk("stall", int'(stall), int'(e.stall));
    chk("remaining", int'(remaining), e.rem);
    chk("busy", int'(busy), int'(e.busy));
    chk("empty", int'(empty), int'(e.empty));
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2 reset_n = 1'b0;
    req = 4'd0;
    shuffle = 1'b0;
    #1;
    model_reset();
    chk("rst_remaining", int'(remaining), m_rem);
    chk("rst_busy", int'(busy), 0);
    chk("rst_empty", int'(empty), 0);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_card", int'(card), 0);
    chk("rst_stall", int'(stall), 0);
    chk("rst_cnt10", int'(dut.r_cnt[10]), m_cnt[10]);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int p, guard;
    n_err = 0;
    n_chk = 0;
    reset_n = 1'b0;
    req = 4'd0;
    pick = 4'd0;
    shuffle = 1'b0;
    do_reset();
    // first edge after release grants a ten to seat 0
    step(4'b0001, 4'd10, 1'b0);
    chk("cnt10", int'(dut.r_cnt[10]), m_cnt[10]);
    do_reset();
    for (int i = 1; i <= 4; i++) step(4'b1111, 4'(i), 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) step(4'b0100, 4'd1, 1'b0);
    step(4'b0010, 4'd1, 1'b0);
    chk("cnt1", int'(dut.r_cnt[1]), m_cnt[1]);
    step(4'b0010, 4'd2, 1'b0);
    step(4'b0000, 4'd3, 1'b0);
    // drain the whole shoe with mixed requests and occasional invalid picks
    do_reset();
    guard = 0;
    while (m_rem > 0 && guard < 300) begin
      guard++;
      if ($urandom_range(0, 7) == 0) p = $urandom_range(11, 15);
      else begin
        p = $urandom_range(1, 10);
        while (m_cnt[p] == 0) p = (p % 10) + 1;
      end
      step(4'($urandom_range(1, 15)), 4'(p), 1'b0);
    end
    chk("drain_state", int'(dut.r_state), int'(EMPTY));
    step(4'b1111, 4'd5, 1'b0);
    step(4'b0011, 4'd2, 1'b0);
    step(4'b0011, 4'd2, 1'b1);
    for (int i = 0; i < 16; i++) step(4'($urandom_range(0, 15)), 4'd10, 1'($urandom_range(0, 1)));
    step(4'b1000, 4'd10, 1'b0);
    // shuffle beats a request, then reset aborts the refill partway through
    step(4'b0100, 4'd3, 1'b1);
    for (int i = 0; i < 5; i++) step(4'b0100, 4'd3, 1'b0);
    do_reset();
    step(4'b0100, 4'd3, 1'b0);
    step(4'b0100, 4'd3, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
